// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word-aligned request at a time, parks a
// response in a one-entry skid buffer when the IF/ID slot is stalled, and flushes on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  output logic [31:0] instrF,
  output logic        validF
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] pcF_q, pcF_d;
  logic [31:0] pc_plus4F_q, pc_plus4F_d;
  logic [31:0] instrF_q, instrF_d;
  logic        validF_q, validF_d;

  logic [31:0] redirect_tgt;
  logic        slot_free;
  logic        req_fire;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  // The slot can accept new data if it is empty or being consumed this cycle.
  assign slot_free    = !validF_q || !stallF;
  assign imem_req     = (state_q == S_REQ) && !redirect && !reset;
  assign imem_addr    = fetch_pc_q;
  assign req_fire     = imem_req && imem_ready;

  assign pcF       = pcF_q;
  assign pc_plus4F = pc_plus4F_q;
  assign instrF    = instrF_q;
  assign validF    = validF_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    pcF_d        = pcF_q;
    pc_plus4F_d  = pc_plus4F_q;
    instrF_d     = instrF_q;
    validF_d     = validF_q;

    if (redirect) begin
      fetch_pc_d = redirect_tgt;
      validF_d   = 1'b0;
      instrF_d   = NOP_INSTR;
      // An outstanding response that has not yet arrived must be swallowed later.
      if ((state_q == S_WAIT) && !imem_rvalid) begin
        state_d = S_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    end else begin
      if (validF_q && !stallF) begin
        validF_d = 1'b0;
        instrF_d = NOP_INSTR;
      end

      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (slot_free) begin
              pcF_d       = req_pc_q;
              pc_plus4F_d = req_pc_q + 32'd4;
              instrF_d    = imem_rdata;
              validF_d    = 1'b1;
              state_d     = S_REQ;
            end else begin
              skid_pc_d    = req_pc_q;
              skid_instr_d = imem_rdata;
              state_d      = S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (!stallF) begin
            pcF_d       = skid_pc_q;
            pc_plus4F_d = skid_pc_q + 32'd4;
            instrF_d    = skid_instr_q;
            validF_d    = 1'b1;
            state_d     = S_REQ;
          end
        end

        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      drop_q       <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= NOP_INSTR;
      pcF_q        <= 32'd0;
      pc_plus4F_q  <= 32'd0;
      instrF_q     <= NOP_INSTR;
      validF_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      drop_q       <= drop_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      pcF_q        <= pcF_d;
      pc_plus4F_q  <= pc_plus4F_d;
      instrF_q     <= instrF_d;
      validF_q     <= validF_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: memory responder, random stall/redirect/reset,
// and a scoreboard holding the expected in-order instruction stream per fetch epoch.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          NCYC     = 6000;

  logic        clk = 1'b0;
  logic        reset, stallF, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pcF, pc_plus4F, instrF;
  logic        validF;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pcF(pcF), .pc_plus4F(pc_plus4F), .instrF(instrF), .validF(validF)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] next_push_pc;
  logic [31:0] exp_req_addr;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          consumed = 0;

  // Memory responder state (what the memory believes is outstanding).
  logic        pend = 1'b0, pend_drop = 1'b0;
  logic [31:0] paddr = 32'd0;
  int          wait_n = 0;
  logic        rst_drv = 1'b1, redir_drv = 1'b0, rv_drv = 1'b0, acc_drv = 1'b0;
  logic [31:0] acc_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_next();
    exp_t e;
    e.pc    = next_push_pc;
    e.instr = mem_word(next_push_pc);
    sb_q.push_back(e);
    next_push_pc = next_push_pc + 32'd4;
  endtask

  task automatic restart(input logic [31:0] base);
    sb_q.delete();
    next_push_pc = base;
    exp_req_addr = base;
    for (int i = 0; i < 8; i++) push_next();
  endtask

  // Stimulus: drives inputs on the falling edge, issues expected stream on reset/redirect.
  initial begin
    int rst_cnt;
    logic prev_rst;
    logic late_rv;
    reset = 1'b1; stallF = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    restart(RESET_PC);
    rst_cnt  = 3;
    prev_rst = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (rst_drv) pend = 1'b0;
      else if (rv_drv) pend = 1'b0;
      else if (acc_drv) begin
        pend      = 1'b1;
        paddr     = acc_addr;
        pend_drop = 1'b0;
        wait_n    = $urandom_range(0, 2);
      end else if (pend) begin
        if (redir_drv) pend_drop = 1'b1;
        if (wait_n > 0) wait_n--;
      end

      if (rst_cnt > 0) begin
        reset = 1'b1; rst_cnt--;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; rst_cnt = $urandom_range(0, 2);
      end else reset = 1'b0;
      late_rv  = prev_rst && !reset;
      prev_rst = reset;

      stallF   = ($urandom_range(0, 99) < 35);
      redirect = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) redirect_pc = {28'hFFF_FFFF, 4'($urandom_range(0, 15))};
      else redirect_pc = $urandom();
      imem_ready = ($urandom_range(0, 99) < 70);

      if (reset) begin
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom();
      end else if (pend && wait_n == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
      end else if (!pend) begin
        imem_rvalid = late_rv || ($urandom_range(0, 99) < 10);
        imem_rdata  = $urandom();
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
      end

      #1;
      rst_drv   = reset;
      redir_drv = redirect;
      rv_drv    = !reset && pend && (wait_n == 0);
      acc_drv   = imem_req && imem_ready;
      acc_addr  = imem_addr;
      #2;
      if (reset) restart(RESET_PC);
      else if (redirect) restart(redirect_pc & 32'hFFFF_FFFC);
      while (sb_q.size() < 8) push_next();
    end
    @(negedge clk);
    check("progress_consumed_ge_200", 32'(consumed >= 200), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Monitor: checks outputs between edges and pops the scoreboard on each consumption.
  initial begin
    exp_t        e;
    logic        prev_reset = 1'b0;
    logic        held = 1'b0;
    logic [31:0] held_pc = 32'd0;
    logic        exp_fill = 1'b0;
    logic [31:0] exp_fill_pc = 32'd0;
    logic        n_fill;
    logic [31:0] n_fill_pc;
    forever begin
      @(negedge clk);
      #2;
      if (prev_reset) begin
        check("reset_validF", 32'(validF), 32'd0);
        check("reset_pcF", pcF, 32'd0);
        check("reset_pc_plus4F", pc_plus4F, 32'd0);
        check("reset_instrF", instrF, NOP);
      end
      if (reset || redirect) check("req_low_on_reset_or_redirect", 32'(imem_req), 32'd0);
      if (!reset && held) check("no_req_in_hold", 32'(imem_req), 32'd0);
      if (imem_req && imem_ready) begin
        check("single_outstanding", 32'(pend), 32'd0);
        check("imem_addr", imem_addr, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
      end
      if (exp_fill) begin
        check("fill_validF", 32'(validF), 32'd1);
        check("fill_pcF", pcF, exp_fill_pc);
      end
      if (!validF) check("bubble_is_nop", instrF, NOP);
      if (!reset && validF && !stallF) begin
        consumed++;
        if (sb_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("pcF", pcF, e.pc);
          check("instrF", instrF, e.instr);
          check("pc_plus4F", pc_plus4F, e.pc + 32'd4);
        end
      end

      n_fill    = 1'b0;
      n_fill_pc = 32'd0;
      if (reset || redirect) held = 1'b0;
      else if (held) begin
        if (!stallF) begin
          n_fill = 1'b1; n_fill_pc = held_pc; held = 1'b0;
        end
      end else if (rv_drv && !pend_drop) begin
        if (!validF || !stallF) begin
          n_fill = 1'b1; n_fill_pc = paddr;
        end else begin
          held = 1'b1; held_pc = paddr;
        end
      end
      exp_fill    = n_fill;
      exp_fill_pc = n_fill_pc;
      prev_reset  = reset;
    end
  end

endmodule
